// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : uart_pkg                                               |
// | Shared UART receiver types: FSM state encoding, bit-rate default |
// | divisor, character width and the even-parity helper.            |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package uart_pkg;

  // 50 MHz clock / 115200 baud
  localparam int CLKDIV_DEFAULT = 434;
  localparam int DATA_BITS      = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  // Even parity: the parity bit equals the XOR of the data bits
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : sync_fifo                                              |
// | Single-clock show-ahead FIFO. Pointers carry one extra wrap bit  |
// | so full/empty come from an MSB/LSB compare. A push into a full   |
// | FIFO is accepted only when a pop happens in the same cycle.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic [WIDTH-1:0]    mem [DEPTH];
  logic                do_push;
  logic                do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Show-ahead head; forced to zero while empty so reset state is defined
  assign head = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

  // Pointer update, wrapping naturally modulo 2**(DEPTH_LOG2+1)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array, written at the current write slot
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_rx                                                |
// | UART receiver: 2-flop rxd synchronizer, start/data/stop FSM with |
// | mid-bit sampling, receive FIFO and sticky error flags.           |
// | Optional even parity bit: define UART_RX_PARITY_EN.              |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKDIV     = CLKDIV_DEFAULT,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  input  logic       rd,
  input  logic       clr,
  output logic [7:0] data,
  output logic       valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int                CNT_W    = $clog2(CLKDIV);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKDIV / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CLKDIV - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic                 sync1;
  logic                 sync2;
  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 par_set;
  logic                 cnt_zero;
  logic                 stop_sample;
  logic                 push;
  logic                 frame_set;
  logic                 overrun_set;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign cnt_zero    = (cnt == '0);
  assign stop_sample = (state == ST_STOP) && cnt_zero;
  assign push        = stop_sample && sync2 && !par_bad;
  assign frame_set   = stop_sample && !sync2;
  assign overrun_set = push && fifo_full && !rd;
  assign valid       = !fifo_empty;

`ifdef UART_RX_PARITY_EN
  assign par_set = (state == ST_DATA) && cnt_zero &&
                   (bit_idx == 4'(DATA_BITS)) &&
                   (sync2 != even_parity(shreg));
`else
  assign par_set = 1'b0;
  assign par_bad = 1'b0;
`endif

  // Two-flop synchronizer; idles high like the line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
    end
  end

  // Receive FSM: half-bit start qualification, then one sample per bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!sync2) begin
            cnt   <= CNT_HALF;
            state <= ST_START;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
          end
        end
        ST_START: begin
          if (cnt_zero) begin
            if (sync2) begin
              state <= ST_IDLE;
            end else begin
              cnt     <= CNT_FULL;
              bit_idx <= '0;
              state   <= ST_DATA;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_DATA: begin
          if (cnt_zero) begin
            cnt <= CNT_FULL;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == 4'(DATA_BITS)) begin
              par_bad <= par_set;
              state   <= ST_STOP;
            end else begin
              shreg   <= {sync2, shreg[DATA_BITS-1:1]};
              bit_idx <= bit_idx + 4'd1;
            end
`else
            shreg <= {sync2, shreg[DATA_BITS-1:1]};
            if (bit_idx == 4'(DATA_BITS - 1)) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
`endif
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_STOP: begin
          if (cnt_zero) begin
            state <= sync2 ? ST_IDLE : ST_BREAK;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_BREAK: begin
          if (sync2) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flags; a setting event outranks a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (overrun_set)    overrun <= 1'b1;
      else if (clr)       overrun <= 1'b0;
      if (frame_set)      frame_err <= 1'b1;
      else if (clr)       frame_err <= 1'b0;
      if (par_set)        parity_err <= 1'b1;
      else if (clr)       parity_err <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH      (DATA_BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (shreg),
    .pop       (rd),
    .head      (data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
`default_nettype wire
